acc_user_mem_channel: RTL and testbench

Memory-side responder for one acc_user channel: it serves the read stream an accelerator pulls through `acc_user_request_read` and sinks the write stream it pushes through `acc_user_request_write`. The block holds a host-loaded read buffer and a write capture buffer, and raises the per-direction done flags the accelerator's exec controller waits on. It sits between the host/testbench memory model and the accelerator top, one instance per channel.

---
 rtl/acc_user_mem_channel.sv | 136 +++++++++++++
 tb/tb_acc_user_mem_channel.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_user_mem_channel.sv
// acc_user_mem_channel: memory-side responder for one acc_user channel.
// Serves a host-loaded read buffer to the accelerator's read stream, captures
// its write stream into a write buffer, and raises per-direction done flags.
module acc_user_mem_channel #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   rd_num_lines,
  input  logic [ADDR_WIDTH:0]   wr_num_lines,
  input  logic                  host_rd_we,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  input  logic [DATA_WIDTH-1:0] host_rd_wdata,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  output logic [DATA_WIDTH-1:0] host_wr_rdata,
  output logic                  acc_user_available_read,
  input  logic                  acc_user_request_read,
  output logic                  acc_user_read_data_valid,
  output logic [DATA_WIDTH-1:0] acc_user_read_data,
  output logic                  acc_user_done_rd_data,
  output logic                  acc_user_available_write,
  input  logic                  acc_user_request_write,
  input  logic [DATA_WIDTH-1:0] acc_user_write_data,
  output logic                  acc_user_done_wr_data,
  output logic                  done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_LINES = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_rd_len;
  logic [ADDR_WIDTH:0]   r_wr_len;
  logic [ADDR_WIDTH:0]   r_rd_cnt;
  logic [ADDR_WIDTH:0]   r_wr_cnt;
  logic                  r_rd_pend;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_host_wr_rdata;
  logic [DATA_WIDTH-1:0] r_rdbuf [DEPTH];
  logic [DATA_WIDTH-1:0] r_wrbuf [DEPTH];

  logic                  w_run;
  logic                  w_active;
  logic                  w_launch;
  logic                  w_rd_avail;
  logic                  w_wr_avail;
  logic                  w_rd_fire;
  logic                  w_wr_fire;
  logic                  w_rd_done;
  logic                  w_wr_done;
  logic [ADDR_WIDTH:0]   w_rd_len_sat;
  logic [ADDR_WIDTH:0]   w_wr_len_sat;

  assign w_run        = (r_state == S_RUN);
  assign w_active     = (r_state != S_IDLE);
  assign w_launch     = start && !w_run;
  assign w_rd_len_sat = (rd_num_lines > MAX_LINES) ? MAX_LINES : rd_num_lines;
  assign w_wr_len_sat = (wr_num_lines > MAX_LINES) ? MAX_LINES : wr_num_lines;

  // A pending read blocks the next request, giving at most one line per two cycles.
  assign w_rd_avail = w_run && !r_rd_pend && (r_rd_cnt < r_rd_len);
  assign w_wr_avail = w_run && (r_wr_cnt < r_wr_len);
  assign w_rd_fire  = w_rd_avail && acc_user_request_read;
  assign w_wr_fire  = w_wr_avail && acc_user_request_write;
  assign w_rd_done  = w_active && (r_rd_cnt == r_rd_len) && !r_rd_pend;
  assign w_wr_done  = w_active && (r_wr_cnt == r_wr_len);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: start launches from IDLE/DONE, RUN ends when both sides finish.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
      S_RUN:          if (w_rd_done && w_wr_done) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Length latching, transfer counters, pending read and served line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_len  <= '0;
      r_wr_len  <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
      r_rd_data <= '0;
    end else if (w_launch) begin
      r_rd_len  <= w_rd_len_sat;
      r_wr_len  <= w_wr_len_sat;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= r_rdbuf[r_rd_cnt[ADDR_WIDTH-1:0]];
        r_rd_cnt  <= r_rd_cnt + ONE;
      end
      if (w_wr_fire) r_wr_cnt <= r_wr_cnt + ONE;
    end
  end

  // Buffer storage: host loads the read buffer outside RUN, accelerator fills the write buffer.
  always_ff @(posedge clk) begin
    if (host_rd_we && !w_run) r_rdbuf[host_rd_addr] <= host_rd_wdata;
    if (w_wr_fire) r_wrbuf[r_wr_cnt[ADDR_WIDTH-1:0]] <= acc_user_write_data;
  end

  // Registered host readback of the write buffer.
  always_ff @(posedge clk) begin
    if (rst) r_host_wr_rdata <= '0;
    else     r_host_wr_rdata <= r_wrbuf[host_wr_addr];
  end

  assign host_wr_rdata            = r_host_wr_rdata;
  assign acc_user_available_read  = w_rd_avail;
  assign acc_user_read_data_valid = r_rd_pend;
  assign acc_user_read_data       = r_rd_data;
  assign acc_user_done_rd_data    = w_rd_done;
  assign acc_user_available_write = w_wr_avail;
  assign acc_user_done_wr_data    = w_wr_done;
  assign done                     = (r_state == S_DONE);

endmodule

// File: tb/tb_acc_user_mem_channel.sv
// Testbench for acc_user_mem_channel: directed steps with randomized data and
// request patterns, checked every cycle against a behavioural channel model.
module tb_acc_user_mem_channel;

  localparam int DW    = 512;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   rd_num_lines;
  logic [AW:0]   wr_num_lines;
  logic          host_rd_we;
  logic [AW-1:0] host_rd_addr;
  logic [DW-1:0] host_rd_wdata;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_rdata;
  logic          acc_user_available_read;
  logic          acc_user_request_read;
  logic          acc_user_read_data_valid;
  logic [DW-1:0] acc_user_read_data;
  logic          acc_user_done_rd_data;
  logic          acc_user_available_write;
  logic          acc_user_request_write;
  logic [DW-1:0] acc_user_write_data;
  logic          acc_user_done_wr_data;
  logic          done;

  acc_user_mem_channel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .rd_num_lines             (rd_num_lines),
    .wr_num_lines             (wr_num_lines),
    .host_rd_we               (host_rd_we),
    .host_rd_addr             (host_rd_addr),
    .host_rd_wdata            (host_rd_wdata),
    .host_wr_addr             (host_wr_addr),
    .host_wr_rdata            (host_wr_rdata),
    .acc_user_available_read  (acc_user_available_read),
    .acc_user_request_read    (acc_user_request_read),
    .acc_user_read_data_valid (acc_user_read_data_valid),
    .acc_user_read_data       (acc_user_read_data),
    .acc_user_done_rd_data    (acc_user_done_rd_data),
    .acc_user_available_write (acc_user_available_write),
    .acc_user_request_write   (acc_user_request_write),
    .acc_user_write_data      (acc_user_write_data),
    .acc_user_done_wr_data    (acc_user_done_wr_data),
    .done                     (done)
  );

  always #5 clk = ~clk;

  // Behavioural model of the channel.
  bit            m_run, m_fin, m_pend, m_host_known;
  int unsigned   m_rd_len, m_wr_len, m_rd_cnt, m_wr_cnt;
  logic [DW-1:0] m_rd_data, m_host_rdata;
  logic [DW-1:0] m_rdmem [DEPTH];
  logic [DW-1:0] m_wrmem [DEPTH];
  bit            m_wrknown [DEPTH];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            pulses;
  logic [DW-1:0] first_data, last_data;

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int unsigned sat(input logic [AW:0] n);
    return (int'(n) > DEPTH) ? DEPTH : int'(n);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    host_rd_we = 1'b0;
    acc_user_request_read = 1'b0;
    acc_user_request_write = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    bit a_rd, a_wr, fin_cond;
    @(posedge clk);
    a_rd = m_run && !m_pend && (m_rd_cnt < m_rd_len);
    a_wr = m_run && (m_wr_cnt < m_wr_len);
    if (rst) begin
      m_run = 0; m_fin = 0; m_pend = 0;
      m_rd_cnt = 0; m_wr_cnt = 0; m_rd_len = 0; m_wr_len = 0;
      m_rd_data = '0; m_host_rdata = '0; m_host_known = 1;
    end else begin
      m_host_rdata = m_wrmem[host_wr_addr];
      m_host_known = m_wrknown[host_wr_addr];
      if (!m_run) begin
        if (host_rd_we) m_rdmem[host_rd_addr] = host_rd_wdata;
        if (start) begin
          m_run = 1; m_fin = 0; m_pend = 0;
          m_rd_len = sat(rd_num_lines); m_wr_len = sat(wr_num_lines);
          m_rd_cnt = 0; m_wr_cnt = 0;
        end
      end else begin
        fin_cond = (m_rd_cnt == m_rd_len) && !m_pend && (m_wr_cnt == m_wr_len);
        if (acc_user_request_write && a_wr) begin
          m_wrmem[m_wr_cnt] = acc_user_write_data;
          m_wrknown[m_wr_cnt] = 1;
          m_wr_cnt++;
        end
        m_pend = 0;
        if (acc_user_request_read && a_rd) begin
          m_rd_data = m_rdmem[m_rd_cnt];
          m_pend = 1;
          m_rd_cnt++;
        end
        if (fin_cond) begin m_run = 0; m_fin = 1; end
      end
    end
    #1;
    chk("avail_rd", acc_user_available_read, m_run && !m_pend && (m_rd_cnt < m_rd_len));
    chk("avail_wr", acc_user_available_write, m_run && (m_wr_cnt < m_wr_len));
    chk("rd_valid", acc_user_read_data_valid, m_pend);
    chk("rd_data", acc_user_read_data, m_rd_data);
    chk("done_rd", acc_user_done_rd_data, (m_run || m_fin) && (m_rd_cnt == m_rd_len) && !m_pend);
    chk("done_wr", acc_user_done_wr_data, (m_run || m_fin) && (m_wr_cnt == m_wr_len));
    chk("done", done, m_fin);
    if (m_host_known) chk("host_rdata", host_wr_rdata, m_host_rdata);
    if (acc_user_read_data_valid) begin
      if (pulses == 0) first_data = acc_user_read_data;
      last_data = acc_user_read_data;
      pulses++;
    end
  endtask

  task automatic start_run(input int unsigned rd, input int unsigned wr);
    start = 1'b1;
    rd_num_lines = rd[AW:0];
    wr_num_lines = wr[AW:0];
    pulses = 0;
    tick();
    start = 1'b0;
  endtask

  // Random requests (percent probabilities) until the model finishes or the budget expires.
  task automatic run_random(input int unsigned rd_pct, input int unsigned wr_pct, input int budget);
    for (int i = 0; i < budget && !m_fin; i++) begin
      acc_user_request_read  = ($urandom_range(99) < rd_pct);
      acc_user_request_write = ($urandom_range(99) < wr_pct);
      acc_user_write_data    = rnd_line();
      host_rd_we             = $urandom_range(1);
      host_rd_addr           = AW'($urandom);
      host_rd_wdata          = rnd_line();
      host_wr_addr           = AW'($urandom);
      tick();
    end
    idle_inputs();
    chk("run_finished", done, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_wrknown[i] = 0;
    m_host_known = 0;
    pulses = 0;
    idle_inputs();
    rst = 1'b1;
    rd_num_lines = '0; wr_num_lines = '0;
    host_rd_addr = '0; host_rd_wdata = '0; host_wr_addr = '0;
    acc_user_write_data = '0;
    tick(); tick();
    chk("reset_done", done, 1'b0);
    chk("reset_rd_data", acc_user_read_data, '0);
    chk("reset_host_rdata", host_wr_rdata, '0);
    rst = 1'b0;

    // Requests while IDLE are ignored; meanwhile load the whole read buffer.
    acc_user_request_read = 1'b1;
    acc_user_request_write = 1'b1;
    acc_user_write_data = rnd_line();
    host_rd_we = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_rd_addr  = AW'(i);
      host_rd_wdata = (i < 4) ? DW'(32'hA0 + i) : rnd_line();
      tick();
    end
    idle_inputs();
    chk("idle_no_pulses", pulses, 0);

    // Read 4 lines, requesting every cycle.
    start_run(4, 0);
    acc_user_request_read = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    idle_inputs();
    chk("rd4_pulses", pulses, 4);
    chk("rd4_first", first_data, DW'(32'hA0));
    chk("rd4_last", last_data, DW'(32'hA3));
    chk("rd4_done", done, 1'b1);

    // Fill write buffer lines 0..7 with random data.
    start_run(0, 8);
    run_random(0, 70, 60);

    // Three back-to-back writes, then a fourth that must be dropped.
    start_run(0, 3);
    acc_user_request_write = 1'b1;
    acc_user_write_data = DW'(32'h11); tick();
    acc_user_write_data = DW'(32'h22); tick();
    acc_user_write_data = DW'(32'h33); tick();
    chk("wr3_avail_low", acc_user_available_write, 1'b0);
    acc_user_write_data = DW'(32'h44); tick();
    idle_inputs();
    for (int a = 0; a < 4; a++) begin
      host_wr_addr = AW'(a);
      tick();
    end
    host_wr_addr = AW'(0); tick(); chk("wr_rb0", host_wr_rdata, DW'(32'h11));
    host_wr_addr = AW'(1); tick(); chk("wr_rb1", host_wr_rdata, DW'(32'h22));
    host_wr_addr = AW'(2); tick(); chk("wr_rb2", host_wr_rdata, DW'(32'h33));
    host_wr_addr = AW'(3); tick();
    chk("wr_rb3_kept", host_wr_rdata, m_wrmem[3]);
    chk("wr_rb3_not_dropped_data", host_wr_rdata == DW'(32'h44), 1'b0);

    // Concurrent read and write of two lines each on the same cycles.
    start_run(2, 2);
    acc_user_request_read = 1'b1;
    acc_user_request_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc_user_write_data = rnd_line();
      tick();
    end
    idle_inputs();
    chk("conc_pulses", pulses, 2);
    chk("conc_done", done, 1'b1);

    // Mid-RUN start must not change the latched counts.
    start_run(6, 6);
    acc_user_request_read = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    start = 1'b1; rd_num_lines = 1; wr_num_lines = 1;
    tick();
    start = 1'b0;
    run_random(80, 60, 100);
    chk("midstart_pulses", pulses, 6);

    // Reset the cycle after an accepted read.
    start_run(3, 0);
    acc_user_request_read = 1'b1;
    tick();
    acc_user_request_read = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", acc_user_read_data_valid, 1'b0);
    chk("rst_avail_rd", acc_user_available_read, 1'b0);
    chk("rst_avail_wr", acc_user_available_write, 1'b0);
    chk("rst_done_rd", acc_user_done_rd_data, 1'b0);
    chk("rst_done_wr", acc_user_done_wr_data, 1'b0);
    chk("rst_rd_data", acc_user_read_data, '0);
    chk("rst_host_rdata", host_wr_rdata, '0);
    pulses = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_no_pulses", pulses, 0);
    start_run(3, 0);
    run_random(100, 0, 20);
    chk("replay_first", first_data, m_rdmem[0]);
    chk("replay_pulses", pulses, 3);

    // Random short runs with random loads between and during them.
    for (int r = 0; r < 6; r++) begin
      start_run($urandom_range(12), $urandom_range(12));
      run_random($urandom_range(30, 100), $urandom_range(30, 100), 200);
    end

    // Oversized read count saturates to the buffer depth.
    start_run(DEPTH + 5, 300);
    run_random(75, 75, 2000);
    chk("sat_pulses", pulses, DEPTH);
    chk("sat_last", last_data, m_rdmem[DEPTH-1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
